fust_s_retire: RTL and testbench
================================

# fust_s_retire

Scalar retire and writeback unit for the scoreboarded scalar pipeline. It accepts completion results from the ALU, LD_ST and BRANCH functional units and buffers one result per unit. Each cycle it picks one result round-robin, drives the single register-file write port, and broadcasts a clear so the scalar FU status table frees that unit's row and clears matching t1/t2 source tags. It is the consumer side of the FU status table; dispatch and issue set rows, and this block releases them.

## Interface
- NUM_FU, 3, number of scalar FUs; index equals the fu_scalar encoding (ALU=0, LD_ST=1, BRANCH=2)
- WORD_W, 32, result data width
- REG_W, 5, register index width
- CLK  in  1  clock; all state updates on the rising edge
- nRST  in  1  reset; asynchronous, active-low
- done_valid  in  NUM_FU  per-FU completion valid
- done_ready  out  NUM_FU  per-FU completion accept
- done_wen  in  NUM_FU  per-FU "result writes rd" flag
- done_rd  in  NUM_FU×REG_W  per-FU destination register
- done_data  in  NUM_FU×WORD_W  per-FU result data
- rf_wen  out  1  register-file write enable
- rf_waddr  out  REG_W  register-file write address
- rf_wdata  out  WORD_W  register-file write data
- clr_valid  out  1  FUST release strobe
- clr_fu  out  FU_S_W  FU whose row is released; also the tag to clear from t1/t2
- pending  out  NUM_FU  per-FU buffer occupied

## Operation
- Per FU i: one-entry buffer {valid, wen, rd, data}. A transfer occurs when done_valid[i] && done_ready[i].
- done_ready[i] = !buf_valid[i] || grant[i]. A buffer may be refilled in the same cycle it retires.
- Arbitration: round-robin over buf_valid, starting at pointer ptr (0..NUM_FU-1). The winner is the first valid index at or after ptr, wrapping. On grant, ptr <= (winner+1) mod NUM_FU. With no grant, ptr holds.
- On grant of FU w:
  - clr_valid=1 and clr_fu=w.
  - rf_wen = buf.wen && (buf.rd != 0); rf_waddr=buf.rd; rf_wdata=buf.data.
  - A write to x0 is suppressed, but the row is still cleared.
- BRANCH typically completes with wen=0. It is then cleared with no register-file write.
- With no grant: rf_wen=0, clr_valid=0, and rf_waddr, rf_wdata and clr_fu are 0.
- Exactly one retirement per cycle, maximum.
- pending[i] = buf_valid[i].

## Timing
- Reset values: all buffers invalid, ptr=0, and every output 0. done_ready is all-ones immediately after reset, because it derives from the empty buffers.
- Reset asserted mid-operation discards all buffered results. No clear is emitted for them; the FUST is reset by the same nRST.
- Latency without bypass: a completion accepted at edge N is eligible at cycle N+1 and appears on rf_*/clr_* in that cycle if it wins. Outputs are combinational from registered buffer state.
- Worst case: an entry waits NUM_FU−1 cycles after becoming eligible.
- Full: when buf_valid[i]=1 and FU i loses arbitration, done_ready[i]=0. FU i must hold its done_* signals stable until accepted.
- Simultaneous completion of all three FUs from empty:
  - All three are accepted.
  - They retire in ptr order over 3 consecutive cycles.

## Configuration
- FUST_S_RETIRE_BYPASS_EN defined:
  - Arbitration also sees incoming transfers for empty buffers (request = buf_valid[i] || done_valid[i]).
  - A winning incoming result retires in the same cycle it arrives, with zero latency, and is not written to the buffer.
  - done_ready is unchanged.
- Undefined: retirement only comes from buffered entries, so latency is at least 1 cycle.

## Structure
- The following belong in the shared types package, next to fu_scalar and fust_s_t:
  - typedef retire_req_t {wen, rd (regbits_t), data (word)}
  - a constant NUM_FU_S = 3
- One sub-module, rr_arbiter: parameterized width, inputs req and advance, outputs a one-hot grant plus the encoded index, holds the pointer internally. It is reusable later for matrix-side retirement.

## Test plan
- Reset → done_ready=3'b111, rf_wen=0, clr_valid=0, pending=0.
- ALU done at cycle 0, rd=5, data=0xDEADBEEF, wen=1 → cycle 1: rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF, clr_fu=ALU; bypass build: the same values in cycle 0.
- All three FUs done in one cycle with ptr=0 (ALU rd=1, LD_ST rd=2, BRANCH wen=0) → clears ALU, LD_ST, BRANCH on consecutive cycles; rf_wen pattern 1,1,0; ptr ends at 0.
- ALU wen=1, rd=0 → clr_valid=1, clr_fu=ALU, rf_wen=0.
- LD_ST buffer held while ALU repeatedly retires → LD_ST done_ready=0 until granted; granted within 2 cycles of eligibility; a new LD_ST completion is accepted in its grant cycle.
- nRST pulled low with 2 entries pending → pending=0, outputs 0 asynchronously; no clr_valid after release.

Source files
------------

// File: rtl/fust_s_retire_pkg.sv
// Shared scalar-pipeline types: FU encoding, FU status row, retire request.
// Bypass of incoming completions is enabled with FUST_S_RETIRE_BYPASS_EN.
package fust_s_retire_pkg;

  localparam int NUM_FU_S  = 3;
  localparam int FU_S_W    = 2;
  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;

  typedef logic [REG_IDX_W-1:0] regbits_t;
  typedef logic [XLEN-1:0]      word;

  typedef enum logic [FU_S_W-1:0] {
    FU_ALU    = 2'd0,
    FU_LD_ST  = 2'd1,
    FU_BRANCH = 2'd2
  } fu_scalar;

  // One row of the scalar FU status table; t1/t2 name the FU producing each source.
  typedef struct packed {
    logic     busy;
    regbits_t rd;
    regbits_t rs1;
    regbits_t rs2;
    logic     t1_valid;
    fu_scalar t1;
    logic     t2_valid;
    fu_scalar t2;
  } fust_s_t;

  typedef struct packed {
    logic     wen;
    regbits_t rd;
    word      data;
  } retire_req_t;

  function automatic logic rf_write_en(input retire_req_t r);
    return r.wen && (r.rd != '0);
  endfunction

endpackage

// File: rtl/fust_s_retire_if.sv
// Completion, register-file write and FUST release signals of the retire unit.
// slave: the retire unit; master: the FUs / register file / FUST side.
interface fust_s_retire_if
  import fust_s_retire_pkg::*;
#(
  parameter int NUM_FU = NUM_FU_S,
  parameter int WORD_W = XLEN,
  parameter int REG_W  = REG_IDX_W,
  parameter int FU_W   = FU_S_W
);

  logic [NUM_FU-1:0]             done_valid;
  logic [NUM_FU-1:0]             done_ready;
  logic [NUM_FU-1:0]             done_wen;
  logic [NUM_FU-1:0][REG_W-1:0]  done_rd;
  logic [NUM_FU-1:0][WORD_W-1:0] done_data;

  logic                          rf_wen;
  logic [REG_W-1:0]              rf_waddr;
  logic [WORD_W-1:0]             rf_wdata;

  logic                          clr_valid;
  logic [FU_W-1:0]               clr_fu;
  logic [NUM_FU-1:0]             pending;

  modport slave (
    input  done_valid, done_wen, done_rd, done_data,
    output done_ready, rf_wen, rf_waddr, rf_wdata, clr_valid, clr_fu, pending
  );

  modport master (
    output done_valid, done_wen, done_rd, done_data,
    input  done_ready, rf_wen, rf_waddr, rf_wdata, clr_valid, clr_fu, pending
  );

endinterface

// File: rtl/fust_s_retire_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; the
// pointer moves past the winner only when the grant is consumed (i_advance).
module fust_s_retire_rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N-1:0]     i_req,
  input  logic             i_advance,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  logic [IDX_W-1:0] r_ptr;
  logic [N-1:0]     w_grant;
  logic [IDX_W-1:0] w_idx;
  logic             w_valid;

  function automatic logic [IDX_W-1:0] f_wrap(input logic [IDX_W-1:0] base,
                                              input int unsigned        off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= N) s = s - N;
    return s[IDX_W-1:0];
  endfunction

  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      logic [IDX_W-1:0] cand;
      cand = f_wrap(r_ptr, k);
      if (!w_valid && i_req[cand]) begin
        w_valid = 1'b1;
        w_idx   = cand;
      end
    end
    if (w_valid) w_grant[w_idx] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_advance && w_valid) begin
      r_ptr <= f_wrap(w_idx, 1);
    end
  end

  assign o_grant = w_grant;
  assign o_idx   = w_idx;
  assign o_valid = w_valid;

endmodule

// File: rtl/fust_s_retire.sv
// Scalar retire/writeback: one result buffer per FU, one round-robin retirement
// per cycle. Define FUST_S_RETIRE_BYPASS_EN to let empty-buffer arrivals retire at once.
module fust_s_retire
  import fust_s_retire_pkg::*;
#(
  parameter int NUM_FU = NUM_FU_S,
  parameter int WORD_W = XLEN,
  parameter int REG_W  = REG_IDX_W
) (
  input logic            CLK,
  input logic            nRST,
  fust_s_retire_if.slave bus
);

  localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0]             r_buf_valid;
  logic [NUM_FU-1:0]             r_buf_wen;
  logic [NUM_FU-1:0][REG_W-1:0]  r_buf_rd;
  logic [NUM_FU-1:0][WORD_W-1:0] r_buf_data;

  logic [NUM_FU-1:0] w_req;
  logic [NUM_FU-1:0] w_grant;
  logic [IDX_W-1:0]  w_idx;
  logic              w_valid;
  logic [NUM_FU-1:0] w_ready;
  logic [NUM_FU-1:0] w_xfer;
  logic [NUM_FU-1:0] w_bypass;

  logic              w_sel_wen;
  logic [REG_W-1:0]  w_sel_rd;
  logic [WORD_W-1:0] w_sel_data;

`ifdef FUST_S_RETIRE_BYPASS_EN
  assign w_req    = r_buf_valid | bus.done_valid;
  // A granted arrival into an empty buffer retires directly and is never stored.
  assign w_bypass = w_grant & ~r_buf_valid;
`else
  assign w_req    = r_buf_valid;
  assign w_bypass = '0;
`endif

  fust_s_retire_rr_arbiter #(
    .N     (NUM_FU),
    .IDX_W (IDX_W)
  ) u_arb (
    .i_clk     (CLK),
    .i_rst_n   (nRST),
    .i_req     (w_req),
    .i_advance (1'b1),
    .o_grant   (w_grant),
    .o_idx     (w_idx),
    .o_valid   (w_valid)
  );

  assign w_ready = ~r_buf_valid | w_grant;
  assign w_xfer  = bus.done_valid & w_ready;

  always_comb begin
    w_sel_wen  = r_buf_wen[w_idx];
    w_sel_rd   = r_buf_rd[w_idx];
    w_sel_data = r_buf_data[w_idx];
`ifdef FUST_S_RETIRE_BYPASS_EN
    if (!r_buf_valid[w_idx]) begin
      w_sel_wen  = bus.done_wen[w_idx];
      w_sel_rd   = bus.done_rd[w_idx];
      w_sel_data = bus.done_data[w_idx];
    end
`endif
  end

  // x0 writes are dropped but the FUST row is still released.
  always_comb begin
    bus.rf_wen    = 1'b0;
    bus.rf_waddr  = '0;
    bus.rf_wdata  = '0;
    bus.clr_valid = 1'b0;
    bus.clr_fu    = '0;
    if (w_valid) begin
      bus.rf_wen    = w_sel_wen && (w_sel_rd != '0);
      bus.rf_waddr  = w_sel_rd;
      bus.rf_wdata  = w_sel_data;
      bus.clr_valid = 1'b1;
      bus.clr_fu    = w_idx;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_buf_valid <= '0;
      r_buf_wen   <= '0;
      r_buf_rd    <= '0;
      r_buf_data  <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (w_xfer[i] && !w_bypass[i]) begin
          r_buf_valid[i] <= 1'b1;
          r_buf_wen[i]   <= bus.done_wen[i];
          r_buf_rd[i]    <= bus.done_rd[i];
          r_buf_data[i]  <= bus.done_data[i];
        end else if (w_grant[i]) begin
          r_buf_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.done_ready = w_ready;
  assign bus.pending    = r_buf_valid;

endmodule

// File: tb/tb_fust_s_retire.sv
// Scoreboard bench for fust_s_retire: a handshake driver feeds per-FU queues,
// a monitor pops expected retirements whenever clr_valid is seen.
module tb_fust_s_retire;
  import fust_s_retire_pkg::*;

`ifdef FUST_S_RETIRE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int LAT = BYP ? 0 : 1;

  typedef struct packed {
    logic [1:0]  fu;
    logic        rf_wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } exp_t;

  logic CLK;
  logic nRST;
  int   n_checks;
  int   n_fail;

  retire_req_t drv_q[3][$];
  exp_t        exp_q[$];

  fust_s_retire_if #(.NUM_FU(3), .WORD_W(32), .REG_W(5), .FU_W(2)) bus ();

  fust_s_retire #(.NUM_FU(3), .WORD_W(32), .REG_W(5)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic send(input int f, input logic wen, input logic [4:0] rd, input logic [31:0] data);
    retire_req_t r;
    r.wen  = wen;
    r.rd   = rd;
    r.data = data;
    drv_q[f].push_back(r);
  endtask

  task automatic exp_ret(input logic [1:0] fu, input logic wen, input logic [4:0] rd,
                         input logic [31:0] data);
    exp_t e;
    e.fu     = fu;
    e.rf_wen = wen;
    e.waddr  = rd;
    e.wdata  = data;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || drv_q[0].size() != 0 || drv_q[1].size() != 0 ||
            drv_q[2].size() != 0 || bus.pending != 3'b000) && n < 50) begin
      @(negedge CLK);
      #1;
      n++;
    end
    check({name, "_drained"}, 64'(exp_q.size()), 64'(0));
    check({name, "_pending"}, 64'(bus.pending), 64'(0));
  endtask

  // Handshake driver: an item leaves its queue only after done_valid && done_ready.
  initial begin : driver
    logic [2:0] acc;
    acc            = '0;
    bus.done_valid = '0;
    bus.done_wen   = '0;
    bus.done_rd    = '0;
    bus.done_data  = '0;
    forever begin
      @(posedge CLK);
      for (int f = 0; f < 3; f++)
        if (acc[f] && drv_q[f].size() > 0) void'(drv_q[f].pop_front());
      #1;
      for (int f = 0; f < 3; f++) begin
        if (drv_q[f].size() > 0) begin
          bus.done_valid[f] = 1'b1;
          bus.done_wen[f]   = drv_q[f][0].wen;
          bus.done_rd[f]    = drv_q[f][0].rd;
          bus.done_data[f]  = drv_q[f][0].data;
        end else begin
          bus.done_valid[f] = 1'b0;
          bus.done_wen[f]   = 1'b0;
          bus.done_rd[f]    = '0;
          bus.done_data[f]  = '0;
        end
      end
      @(negedge CLK);
      acc = nRST ? (bus.done_valid & bus.done_ready) : 3'b000;
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (nRST) begin
        if (bus.clr_valid) begin
          if (exp_q.size() == 0) begin
            check("spurious_clr_valid", 64'(bus.clr_valid), 64'(0));
          end else begin
            e = exp_q.pop_front();
            check("retire", 64'({bus.clr_fu, bus.rf_wen, bus.rf_waddr, bus.rf_wdata}), 64'(e));
          end
        end else begin
          check("idle_outputs_zero",
                64'({bus.clr_fu, bus.rf_wen, bus.rf_waddr, bus.rf_wdata}), 64'(0));
        end
      end
    end
  end

  initial begin : main
    n_checks = 0;
    n_fail   = 0;
    nRST     = 1'b0;
    #12;
    check("rst_done_ready", 64'(bus.done_ready), 64'(3'b111));
    check("rst_rf_wen",     64'(bus.rf_wen),     64'(0));
    check("rst_clr_valid",  64'(bus.clr_valid),  64'(0));
    check("rst_pending",    64'(bus.pending),    64'(0));
    @(negedge CLK);
    #1 nRST = 1'b1;

    // single ALU completion and its latency
    send(0, 1'b1, 5'd5, 32'hDEADBEEF);
    exp_ret(2'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    @(negedge CLK);
    check("alu_c0_clr_valid", 64'(bus.clr_valid), 64'(BYP));
    @(negedge CLK);
    check("alu_c1_clr_valid", 64'(bus.clr_valid), 64'(!BYP));
    wait_idle("alu_single");

    // write to x0: row released, no register write
    send(0, 1'b1, 5'd0, 32'h0000_1111);
    exp_ret(2'd0, 1'b0, 5'd0, 32'h0000_1111);
    wait_idle("alu_x0");

    // LD_ST then BRANCH (wen=0), brings ptr back to 0
    send(1, 1'b1, 5'd7, 32'h0000_1234);
    send(2, 1'b0, 5'd3, 32'h0000_0055);
    exp_ret(2'd1, 1'b1, 5'd7, 32'h0000_1234);
    exp_ret(2'd2, 1'b0, 5'd3, 32'h0000_0055);
    wait_idle("ldst_branch");

    // all three at once from empty with ptr=0
    send(0, 1'b1, 5'd1, 32'h0000_00A1);
    send(1, 1'b1, 5'd2, 32'h0000_00B2);
    send(2, 1'b0, 5'd0, 32'h0000_00C3);
    exp_ret(2'd0, 1'b1, 5'd1, 32'h0000_00A1);
    exp_ret(2'd1, 1'b1, 5'd2, 32'h0000_00B2);
    exp_ret(2'd2, 1'b0, 5'd0, 32'h0000_00C3);
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      if (k == 0) check("all3_c0_done_ready", 64'(bus.done_ready), 64'(3'b111));
      check($sformatf("all3_c%0d_clr_valid", k), 64'(bus.clr_valid),
            64'((k >= LAT) && (k < LAT + 3)));
    end
    wait_idle("all3");

    // ptr must be back at 0: ALU beats LD_ST
    send(1, 1'b1, 5'd4, 32'h0000_0044);
    send(0, 1'b1, 5'd3, 32'h0000_0033);
    exp_ret(2'd0, 1'b1, 5'd3, 32'h0000_0033);
    exp_ret(2'd1, 1'b1, 5'd4, 32'h0000_0044);
    wait_idle("ptr_wrap");

    // LD_ST held full while ALU keeps completing (ptr=2 here)
    send(0, 1'b1, 5'd10, 32'hA0A0_0000);
    send(0, 1'b1, 5'd12, 32'hA1A1_0001);
    send(0, 1'b1, 5'd14, 32'hA2A2_0002);
    send(1, 1'b1, 5'd11, 32'hB0B0_0000);
    send(1, 1'b1, 5'd13, 32'hB1B1_0001);
    exp_ret(2'd0, 1'b1, 5'd10, 32'hA0A0_0000);
    exp_ret(2'd1, 1'b1, 5'd11, 32'hB0B0_0000);
    exp_ret(2'd0, 1'b1, 5'd12, 32'hA1A1_0001);
    exp_ret(2'd1, 1'b1, 5'd13, 32'hB1B1_0001);
    exp_ret(2'd0, 1'b1, 5'd14, 32'hA2A2_0002);
`ifndef FUST_S_RETIRE_BYPASS_EN
    @(negedge CLK);
    @(negedge CLK);
    check("held_c1_grant_alu",    64'({bus.clr_valid, bus.clr_fu}), 64'(3'b100));
    check("held_c1_ldst_ready",   64'(bus.done_ready[1]), 64'(0));
    @(negedge CLK);
    check("held_c2_grant_ldst",   64'({bus.clr_valid, bus.clr_fu}), 64'(3'b101));
    check("held_c2_ldst_refill",  64'(bus.done_ready[1]), 64'(1));
`endif
    wait_idle("held");

    // async reset with two completions outstanding (ptr=1 here)
    send(0, 1'b1, 5'd6, 32'h0000_0066);
    send(1, 1'b1, 5'd8, 32'h0000_0088);
    if (BYP) exp_ret(2'd1, 1'b1, 5'd8, 32'h0000_0088);
    @(negedge CLK);
    @(posedge CLK);
    #2;
    check("pre_rst_pending", 64'(bus.pending), 64'(BYP ? 3'b001 : 3'b011));
    nRST = 1'b0;
    #1;
    check("mid_rst_pending",    64'(bus.pending),    64'(0));
    check("mid_rst_clr_valid",  64'(bus.clr_valid),  64'(0));
    check("mid_rst_rf_outputs", 64'({bus.rf_wen, bus.rf_waddr, bus.rf_wdata, bus.clr_fu}), 64'(0));
    check("mid_rst_done_ready", 64'(bus.done_ready), 64'(3'b111));
    @(negedge CLK);
    #1 nRST = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      check($sformatf("post_rst_c%0d_clr_valid", k), 64'(bus.clr_valid), 64'(0));
    end

    wait_idle("final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
